// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches words from imem and hands them to control with valid/accept
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_accept,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;
    localparam logic [7:0] TO_LAST = TIMEOUT_CYCLES[7:0] - 8'd1;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d;
    logic [7:0]  cnt_q, cnt_d;
    assign imem_req    = state_q == REQ;
    assign instr_valid = state_q == HOLD;
    assign fetch_fault = state_q == FAULT;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    // state and datapath registers; reset abandons any outstanding request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            cnt_q      <= cnt_d;
        end
    end
    // next state: fetch sequencing, then a redirect overrides everything outside FAULT
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (imem_ready) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    cnt_d      = '0;
                    state_d    = HOLD;
                end else if (cnt_q == TO_LAST) begin
                    state_d = FAULT;
                end
            end
            HOLD: begin
                if (instr_accept) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = REQ;
                end
            end
            default: state_d = FAULT;
        endcase
        if (redirect_valid && state_q != FAULT) begin
            pc_d       = redirect_pc;
            cnt_d      = '0;
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            state_d    = redirect_pc[1:0] != 2'b00 ? FAULT : REQ;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed fetch scenarios with a scoreboard of delivered instructions
module tb_instr_fetch_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        imem_req, imem_ready, instr_valid, instr_accept, redirect_valid, fetch_fault;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
    logic        mem_en, mem_ready, force_en, ready_force, acc_en, acc_auto, acc_man, vprev;
    logic [31:0] mem_rdata, force_data, m_last, hold_i, hold_p;
    logic [63:0] exp_q[$];
    logic [63:0] e;
    int          lat, acc_delay, m_cnt, hcnt;
    int          errors = 0, checks = 0;

    assign imem_ready   = mem_ready | ready_force;
    assign imem_rdata   = force_en ? force_data : mem_rdata;
    assign instr_accept = acc_auto | acc_man;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_accept(instr_accept), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a == 32'h0 ? 32'h0050_0093 : a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // memory: ready after lat consecutive request cycles on the same address
    initial begin
        m_last = 32'h1; m_cnt = 0; mem_ready = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (imem_addr !== m_last) m_cnt = 0;
                m_last = imem_addr;
                m_cnt++;
                mem_ready = mem_en && m_cnt >= lat;
                mem_rdata = data_of(imem_addr);
            end else begin
                m_cnt = 0; m_last = 32'h1; mem_ready = 1'b0;
            end
        end
    end

    // consumer: accepts once an instruction has been held for more than acc_delay cycles
    initial begin
        hcnt = 0; acc_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (instr_valid) begin
                hcnt++;
                acc_auto = acc_en && hcnt > acc_delay;
            end else begin
                hcnt = 0; acc_auto = 1'b0;
            end
        end
    end

    // monitor: pops on each newly presented instruction, checks stability while held
    initial begin
        vprev = 1'b0; hold_i = '0; hold_p = '0;
        forever begin
            @(negedge clk);
            if (instr_valid) begin
                if (!vprev) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_fetch: got pc %h instr %h expected none", instr_pc, instr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("fetch_pc", instr_pc, e[63:32]);
                        chk("fetch_instr", instr, e[31:0]);
                    end
                    hold_i = instr; hold_p = instr_pc;
                end else begin
                    chk("hold_instr", instr, hold_i);
                    chk("hold_pc", instr_pc, hold_p);
                end
            end
            vprev = instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        mem_en = 1'b1; lat = 1; force_en = 1'b0; force_data = '0; ready_force = 1'b0;
        acc_en = 1'b1; acc_delay = 0; acc_man = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        // basic single-cycle fetch with immediate accept
        step(2);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        exp_q.push_back({32'h0, 32'h0050_0093});
        exp_q.push_back({32'h4, data_of(32'h4)});
        reset = 1'b0;
        step; chk("t1_req_c1", 32'(imem_req), 32'd1); chk("t1_addr_c1", imem_addr, 32'h0);
        step; chk("t1_valid_c2", 32'(instr_valid), 32'd1);
        step; chk("t1_req_next", 32'(imem_req), 32'd1); chk("t1_addr_next", imem_addr, 32'h4);
        acc_en = 1'b0;
        step; mem_en = 1'b0;
        step(2);
        // 3-cycle memory, accept after 2 extra hold cycles
        reset = 1'b1; lat = 3; acc_delay = 2; acc_en = 1'b1; mem_en = 1'b1;
        step; exp_q.push_back({32'h0, 32'h0050_0093}); reset = 1'b0;
        step; chk("t2_req1", 32'(imem_req), 32'd1);
        step; chk("t2_req2", 32'(imem_req), 32'd1);
        step; chk("t2_req3", 32'(imem_req), 32'd1); chk("t2_not_valid", 32'(instr_valid), 32'd0);
        step; chk("t2_valid", 32'(instr_valid), 32'd1); chk("t2_pc_h1", imem_addr, 32'h0);
        step; chk("t2_pc_h2", imem_addr, 32'h0);
        step; chk("t2_pc_h3", imem_addr, 32'h0); mem_en = 1'b0;
        step; chk("t2_addr_acc", imem_addr, 32'h4); chk("t2_req_acc", 32'(imem_req), 32'd1);
        acc_en = 1'b0;
        step(2);
        // redirect together with accept in HOLD
        reset = 1'b1; lat = 1; mem_en = 1'b1;
        step;
        exp_q.push_back({32'h10, data_of(32'h10)});
        exp_q.push_back({32'h40, data_of(32'h40)});
        redirect_valid = 1'b1; redirect_pc = 32'h10; reset = 1'b0;
        step; redirect_valid = 1'b0; chk("t3_addr_idle_redir", imem_addr, 32'h10);
        step; chk("t3_hold_pc", instr_pc, 32'h10);
        redirect_valid = 1'b1; redirect_pc = 32'h40; acc_man = 1'b1;
        step; redirect_valid = 1'b0; acc_man = 1'b0;
        chk("t3_valid_drop", 32'(instr_valid), 32'd0);
        chk("t3_addr_redir", imem_addr, 32'h40);
        chk("t3_req_redir", 32'(imem_req), 32'd1);
        step; mem_en = 1'b0;
        step(2);
        // redirect in REQ while a response arrives
        reset = 1'b1; mem_en = 1'b1;
        step; exp_q.push_back({32'h80, data_of(32'h80)}); reset = 1'b0;
        step; force_en = 1'b1; force_data = 32'hDEAD_BEEF; redirect_valid = 1'b1; redirect_pc = 32'h80;
        step; redirect_valid = 1'b0; force_en = 1'b0;
        chk("t4_instr_kept", instr, 32'h0);
        chk("t4_valid", 32'(instr_valid), 32'd0);
        chk("t4_addr", imem_addr, 32'h80);
        chk("t4_req", 32'(imem_req), 32'd1);
        step; mem_en = 1'b0;
        step(2);
        // timeout after 4 REQ cycles, then inputs ignored
        reset = 1'b1;
        step; reset = 1'b0;
        step(4); chk("t5_req4", 32'(imem_req), 32'd1); chk("t5_fault_before", 32'(fetch_fault), 32'd0);
        step; chk("t5_fault", 32'(fetch_fault), 32'd1); chk("t5_req_off", 32'(imem_req), 32'd0);
        mem_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; acc_man = 1'b1;
        step(3);
        chk("t5_fault_sticky", 32'(fetch_fault), 32'd1);
        chk("t5_req_stuck", 32'(imem_req), 32'd0);
        chk("t5_addr_ignored", imem_addr, 32'h0);
        chk("t5_valid_off", 32'(instr_valid), 32'd0);
        redirect_valid = 1'b0; acc_man = 1'b0; mem_en = 1'b0;
        // misaligned redirect
        reset = 1'b1;
        step; reset = 1'b0;
        step; redirect_valid = 1'b1; redirect_pc = 32'h42;
        step; redirect_valid = 1'b0;
        chk("t5m_fault", 32'(fetch_fault), 32'd1);
        chk("t5m_req", 32'(imem_req), 32'd0);
        chk("t5m_addr", imem_addr, 32'h42);
        chk("t5m_valid", 32'(instr_valid), 32'd0);
        step(2); chk("t5m_sticky", 32'(fetch_fault), 32'd1);
        // pc wrap and asynchronous reset in REQ
        reset = 1'b1; mem_en = 1'b1; acc_en = 1'b1; acc_delay = 0;
        step;
        exp_q.push_back({32'hFFFF_FFFC, data_of(32'hFFFF_FFFC)});
        exp_q.push_back({32'h0, 32'h0050_0093});
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; reset = 1'b0;
        step; redirect_valid = 1'b0; chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        step;
        step; chk("t6_addr_wrap", imem_addr, 32'h0); chk("t6_req_wrap", 32'(imem_req), 32'd1);
        acc_en = 1'b0;
        step; mem_en = 1'b0; acc_man = 1'b1;
        step; acc_man = 1'b0; chk("t6_req_pre_rst", 32'(imem_req), 32'd1); chk("t6_addr4", imem_addr, 32'h4);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_req", 32'(imem_req), 32'd0);
        chk("t6_async_addr", imem_addr, 32'h0);
        chk("t6_async_valid", 32'(instr_valid), 32'd0);
        chk("t6_async_instr", instr, 32'h0);
        step; force_en = 1'b1; force_data = 32'hDEAD_BEEF; ready_force = 1'b1; reset = 1'b0;
        step; ready_force = 1'b0; force_en = 1'b0;
        chk("t6_late_instr", instr, 32'h0);
        chk("t6_late_req", 32'(imem_req), 32'd1);
        chk("t6_late_valid", 32'(instr_valid), 32'd0);
        step; chk("t6_late_valid2", 32'(instr_valid), 32'd0);
        reset = 1'b1;
        step;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
